// File: rtl/reel_pkg.sv
// Shared types and helpers for the reel stop controller: FSM state encoding,
// per-reel step period and counter-width helpers.
package reel_pkg;

  localparam int MAX_REELS = 16;

  typedef enum logic [1:0] {
    BLINK = 2'd0,
    SPIN  = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Step period of reel idx in clock cycles.
  function automatic int period(input int idx, input int base_div, input int div_step);
    return base_div + idx * div_step;
  endfunction

  // Width of a counter that holds 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reel_counter.sv
// One reel: clock-enable divider, modulo code counter and spinning flag.
// A stop on the same edge as a step wins, so the code keeps its pre-edge value.
module reel_counter
  import reel_pkg::*;
#(
  parameter int MOD           = 10,
  parameter int CODE_W        = 4,
  parameter int PERIOD        = 4,
  parameter bit SPIN_AT_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [CODE_W-1:0] code,
  output logic              spinning
);

  localparam int                DIV_W     = cnt_w(PERIOD);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PERIOD - 1);
  localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(MOD - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code     <= '0;
      div      <= '0;
      spinning <= SPIN_AT_RESET;
    end else if (start) begin
      spinning <= 1'b1;
      div      <= '0;
    end else if (spinning) begin
      if (stop) begin
        spinning <= 1'b0;
      end else if (div == DIV_LAST) begin
        div  <= '0;
        code <= (code == CODE_LAST) ? '0 : code + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reel_stop_controller.sv
// N-reel selecting-machine core: startup blink, spinning reels, ordered stops,
// all-stopped/match result and restart. Define REEL_ANY_ORDER_EN to accept stops in any order.
module reel_stop_controller
  import reel_pkg::*;
#(
  parameter int NUM_REELS      = 7,
  parameter int MOD            = 10,
  parameter int CODE_W         = 4,
  parameter int BASE_DIV       = 4,
  parameter int DIV_STEP       = 2,
  parameter int STARTUP_BLINKS = 6,
  parameter int BLINK_DIV      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REELS-1:0]        stop_pulse,
  input  logic                        restart,
  output logic [NUM_REELS*CODE_W-1:0] code,
  output logic [NUM_REELS-1:0]        spinning,
  output logic                        blink,
  output logic                        all_stopped,
  output logic                        match
);

  // With no blink phase the machine comes out of reset already spinning.
  localparam bit               SKIP_BLINK  = (STARTUP_BLINKS == 0);
  localparam state_t           RESET_STATE = SKIP_BLINK ? SPIN : BLINK;
  localparam int               HB_W        = cnt_w(STARTUP_BLINKS + 1);
  localparam int               BD_W        = cnt_w(BLINK_DIV);
  localparam logic [BD_W-1:0]  BD_LAST     = BD_W'(BLINK_DIV - 1);
  localparam logic [HB_W-1:0]  HB_LAST     = HB_W'(STARTUP_BLINKS - 1);

  state_t              state, state_next;
  logic [HB_W-1:0]     hb;
  logic [BD_W-1:0]     bdiv;
  logic [NUM_REELS-1:0] eligible;
  logic [NUM_REELS-1:0] stop_acc;
  logic                start_all;
  logic                enter_done;
  logic                codes_equal;

`ifdef REEL_ANY_ORDER_EN
  assign eligible = spinning;
`else
  // Only the highest-index spinning reel may stop; the reel above it must be idle.
  logic [NUM_REELS:0] sp_ext;
  assign sp_ext   = {1'b0, spinning};
  assign eligible = spinning & ~sp_ext[NUM_REELS:1];
`endif

  always_comb begin
    codes_equal = 1'b1;
    for (int i = 1; i < NUM_REELS; i++) begin
      if (code[i*CODE_W +: CODE_W] != code[CODE_W-1:0]) codes_equal = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    start_all  = 1'b0;
    stop_acc   = '0;
    enter_done = 1'b0;
    case (state)
      BLINK: begin
        if (bdiv == BD_LAST && hb == HB_LAST) begin
          state_next = SPIN;
          start_all  = 1'b1;
        end
      end
      SPIN: begin
        stop_acc = stop_pulse & eligible;
        if (stop_acc != '0 && (spinning & ~stop_acc) == '0) begin
          state_next = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        if (restart) begin
          state_next = SPIN;
          start_all  = 1'b1;
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESET_STATE;
      hb          <= '0;
      bdiv        <= '0;
      all_stopped <= 1'b0;
      match       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == BLINK) begin
        if (bdiv == BD_LAST) begin
          bdiv <= '0;
          hb   <= hb + 1'b1;
        end else begin
          bdiv <= bdiv + 1'b1;
        end
      end
      // Codes are frozen on the final-stop edge, so the pre-edge compare is the result.
      if (enter_done) begin
        all_stopped <= 1'b1;
        match       <= codes_equal;
      end else if (start_all) begin
        all_stopped <= 1'b0;
        match       <= 1'b0;
      end
    end
  end

  assign blink = (state == BLINK) && !hb[0];

  for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
    reel_counter #(
      .MOD          (MOD),
      .CODE_W       (CODE_W),
      .PERIOD       (period(i, BASE_DIV, DIV_STEP)),
      .SPIN_AT_RESET(SKIP_BLINK)
    ) u_reel (
      .clk     (clk),
      .rst     (rst),
      .start   (start_all),
      .stop    (stop_acc[i]),
      .code    (code[i*CODE_W +: CODE_W]),
      .spinning(spinning[i])
    );
  end

endmodule

// File: tb/tb_reel_stop_controller.sv
// Directed bench for reel_stop_controller (3 reels, mod 4, periods 2/3/4, 2x3-cycle blink).
// Expected snapshots are queued per cycle; a negedge monitor pops and compares them.
module tb_reel_stop_controller;

  localparam int NR     = 3;
  localparam int CW     = 2;
  localparam int SNAP_W = NR * CW + NR + 3;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      stop_pulse;
  logic               restart;
  logic [NR*CW-1:0]   code;
  logic [NR-1:0]      spinning;
  logic               blink;
  logic               all_stopped;
  logic               match;

  reel_stop_controller #(
    .NUM_REELS     (NR),
    .MOD           (4),
    .CODE_W        (CW),
    .BASE_DIV      (2),
    .DIV_STEP      (1),
    .STARTUP_BLINKS(2),
    .BLINK_DIV     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stop_pulse (stop_pulse),
    .restart    (restart),
    .code       (code),
    .spinning   (spinning),
    .blink      (blink),
    .all_stopped(all_stopped),
    .match      (match)
  );

  // clock / cycle counter; cycle 0 is the first cycle after the initial reset release
  int cyc = 0;
  bit started = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (started) cyc <= cyc + 1;

  // scoreboard
  logic [SNAP_W-1:0] exp_q[$];
  int                exp_cyc_q[$];
  int                checks = 0;
  int                errors = 0;

  function automatic logic [SNAP_W-1:0] snap(input logic [1:0] c2, input logic [1:0] c1,
                                             input logic [1:0] c0, input logic [2:0] sp,
                                             input logic bl, input logic as, input logic m);
    return {c2, c1, c0, sp, bl, as, m};
  endfunction

  task automatic expect_at(input int c, input logic [SNAP_W-1:0] v);
    exp_cyc_q.push_back(c);
    exp_q.push_back(v);
  endtask

  always @(negedge clk) begin
    logic [SNAP_W-1:0] obs;
    logic [SNAP_W-1:0] e;
    int                ec;
    if (started) begin
      obs = {code, spinning, blink, all_stopped, match};
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        ec = exp_cyc_q.pop_front();
        e  = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL cycle_%0d: snapshot not sampled, required %h", ec, e);
      end
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        ec = exp_cyc_q.pop_front();
        e  = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL cycle_%0d: got code=%h spin=%b blink=%b done=%b match=%b, required code=%h spin=%b blink=%b done=%b match=%b",
                   ec, obs[SNAP_W-1 -: NR*CW], obs[5:3], obs[2], obs[1], obs[0],
                   e[SNAP_W-1 -: NR*CW], e[5:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic at_cycle(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_stop(input int k, input logic [NR-1:0] mask);
    at_cycle(k);
    stop_pulse = mask;
    @(posedge clk);
    #1;
    stop_pulse = '0;
  endtask

  task automatic pulse_restart(input int k);
    at_cycle(k);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    stop_pulse = '0;
    restart    = 1'b0;

    // blink phase, then free spin (codes: c2 c1 c0)
    expect_at(0,  snap(0, 0, 0, 3'b000, 1, 0, 0));
    expect_at(2,  snap(0, 0, 0, 3'b000, 1, 0, 0));
    expect_at(3,  snap(0, 0, 0, 3'b000, 0, 0, 0));
    expect_at(5,  snap(0, 0, 0, 3'b000, 0, 0, 0));
    expect_at(6,  snap(0, 0, 0, 3'b111, 0, 0, 0));
    expect_at(8,  snap(0, 0, 1, 3'b111, 0, 0, 0));
    expect_at(9,  snap(0, 1, 1, 3'b111, 0, 0, 0));
    expect_at(10, snap(1, 1, 2, 3'b111, 0, 0, 0));
    expect_at(14, snap(2, 2, 0, 3'b111, 0, 0, 0));
    // out-of-order stop dropped, ordered stops, stop wins over reel 1 tick, mismatch
    expect_at(16, snap(2, 3, 1, 3'b111, 0, 0, 0));
    expect_at(17, snap(2, 3, 1, 3'b011, 0, 0, 0));
    expect_at(21, snap(2, 0, 3, 3'b001, 0, 0, 0));
    expect_at(23, snap(2, 0, 0, 3'b000, 0, 1, 0));
    expect_at(26, snap(2, 0, 0, 3'b000, 0, 1, 0));
    // restart keeps codes, clears flags; restart during SPIN ignored
    expect_at(28, snap(2, 0, 0, 3'b111, 0, 0, 0));
    expect_at(29, snap(2, 0, 0, 3'b111, 0, 0, 0));
    expect_at(30, snap(2, 0, 1, 3'b111, 0, 0, 0));
    expect_at(34, snap(3, 2, 3, 3'b111, 0, 0, 0));
    // stop everything at code 0 -> match
    expect_at(37, snap(0, 3, 0, 3'b011, 0, 0, 0));
    expect_at(39, snap(0, 3, 1, 3'b011, 0, 0, 0));
    expect_at(42, snap(0, 0, 3, 3'b001, 0, 0, 0));
    expect_at(45, snap(0, 0, 0, 3'b000, 0, 1, 1));
    // asynchronous reset mid-SPIN, then a fresh start-up
    expect_at(50, snap(0, 0, 0, 3'b000, 1, 0, 0));
    expect_at(52, snap(0, 0, 0, 3'b000, 1, 0, 0));
    expect_at(55, snap(0, 0, 0, 3'b000, 0, 0, 0));
    expect_at(58, snap(0, 0, 0, 3'b111, 0, 0, 0));
`ifdef REEL_ANY_ORDER_EN
    expect_at(61, snap(0, 0, 1, 3'b000, 0, 1, 0));
`else
    expect_at(61, snap(0, 1, 1, 3'b011, 0, 0, 0));
`endif

    @(posedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    started = 1'b1;

    pulse_stop(15, 3'b001);
    pulse_stop(16, 3'b100);
    pulse_stop(20, 3'b010);
    pulse_stop(22, 3'b001);
    pulse_stop(24, 3'b100);
    pulse_restart(27);
    pulse_restart(33);
    pulse_stop(36, 3'b100);
    pulse_stop(38, 3'b101);
    pulse_stop(41, 3'b010);
    pulse_stop(44, 3'b001);
    pulse_restart(46);
    at_cycle(50);
    rst = 1'b1;
    at_cycle(52);
    rst = 1'b0;
    pulse_stop(60, 3'b111);
    at_cycle(63);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d snapshots never sampled, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reel_stop_controller.md
# reel_stop_controller

Parametrised N-reel selecting-machine core: startup blink phase, then N independent modulo counters ("reels") each advancing at its own rate, stopped one by one by pre-debounced stop pulses, with an all-stopped/match result and restart. Single clock domain: per-reel rates come from clock enables, not divided clocks. Sits between the button debounce stage and the seven-segment/lattice decoders, which consume `code` and `blink`.

## Interface
- `NUM_REELS`, 7, number of reels (1..16)
- `MOD`, 10, reel modulus; every reel counts 0..MOD-1
- `CODE_W`, 4, bits per reel code; must be ≥ clog2(MOD)
- `BASE_DIV`, 4, step period of reel 0 in clk cycles (≥1)
- `DIV_STEP`, 2, extra cycles of period per reel index; reel i period P(i) = BASE_DIV + i*DIV_STEP
- `STARTUP_BLINKS`, 6, blink half-periods before spinning (0 = skip)
- `BLINK_DIV`, 8, clk cycles per blink half-period (≥1)

Ports:
- `clk` in 1, system clock
- `rst` in 1, reset; asynchronous, active-high
- `stop_pulse` in NUM_REELS, one-cycle stop request per reel, already debounced
- `restart` in 1, one-cycle pulse; respin from DONE
- `code` out NUM_REELS*CODE_W, reel i at [i*CODE_W +: CODE_W]
- `spinning` out NUM_REELS, reel i currently advancing
- `blink` out 1, all-on/all-off display request during startup
- `all_stopped` out 1, high in DONE
- `match` out 1, high in DONE when all codes equal

## Operation
- States: BLINK → SPIN → DONE; DONE → SPIN on `restart`. No other transitions except reset.
- Reset: state BLINK (SPIN if STARTUP_BLINKS=0), all `code`=0, `spinning`=0, `blink`=1, `all_stopped`=0, `match`=0, all dividers 0.
- BLINK: half-period counter hb increments every BLINK_DIV cycles; `blink` = ~hb[0]. On the edge where hb reaches STARTUP_BLINKS: state SPIN, `blink`=0, `spinning` all 1, reel dividers 0. `stop_pulse` and `restart` ignored.
- SPIN: reel i divider counts 0..P(i)-1; on the edge where it equals P(i)-1 with `spinning[i]`=1, code i ← (code i = MOD-1) ? 0 : code i + 1, divider ← 0.
- Stop acceptance (strict order): reels stop from NUM_REELS-1 down to 0. `stop_pulse[i]` accepted only if `spinning[i]`=1 and (i = NUM_REELS-1 or `spinning[i+1]`=0). Non-eligible pulses dropped, not queued. At most one reel stops per cycle.
- Accepted stop: `spinning[i]` ← 0 on that edge; if the reel's tick falls on the same edge, stop wins — code holds its pre-edge value.
- When the last spinning reel stops: state DONE on the same edge; `all_stopped`=1, `match` = all codes equal, both registered with the final codes.
- DONE: codes frozen; `stop_pulse` ignored. `restart` → SPIN: `spinning` all 1, dividers 0, codes retained, `all_stopped`/`match` ← 0.
- `restart` outside DONE ignored. `rst` at any time aborts immediately to reset values.

## Timing
- Reel i first advance exactly P(i) cycles after the SPIN-entry edge; thereafter every P(i) cycles.
- Stop latency: `spinning[i]` falls 1 cycle after accepted pulse.
- `all_stopped`/`match` rise on the edge accepting the final stop.
- BLINK duration: STARTUP_BLINKS*BLINK_DIV cycles.
- Wrap: MOD-1 → 0 in one step; no other values reachable.

## Configuration
- `REEL_ANY_ORDER_EN` defined: any spinning reel's pulse accepted regardless of order; multiple simultaneous pulses all accepted on one edge; DONE entered when the final one stops, including when all remaining stop together.
- Not defined: strict descending order as above.

## Structure
- Package `reel_pkg`: state enum (BLINK, SPIN, DONE), function period(i) and divider-width helper, shared localparams.
- Sub-module `reel_counter`: one reel's divider, modulo counter, spinning flag, stop/start inputs; instantiated NUM_REELS times via generate. Top holds FSM, blink counter, stop-eligibility and match logic.

## Test plan
(NUM_REELS=3, MOD=4, CODE_W=2, BASE_DIV=2, DIV_STEP=1, STARTUP_BLINKS=2, BLINK_DIV=3)
- Release reset → `blink` 1 for cycles 0-2, 0 for 3-5; edge 6 SPIN, `spinning`=3'b111.
- Free spin → reel 0 steps every 2, reel 1 every 3, reel 2 every 4 cycles; reel 0 wraps 3→0 after 8 cycles.
- Pulse `stop_pulse[0]` first → ignored; pulse [2], [1], [0] in order → each `spinning` bit falls next cycle; `all_stopped`=1 on third.
- Stop pulse coinciding with tick → code keeps pre-tick value; stop all at equal codes (e.g. 1,1,1) → `match`=1; unequal → `match`=0.
- In DONE pulse `restart` → SPIN, codes unchanged, flags cleared, reel 0 advances 2 cycles later.
- Assert `rst` mid-SPIN → outputs at reset values immediately; with `REEL_ANY_ORDER_EN`, pulse 3'b111 in one cycle → DONE next edge.
